// File: rtl/snow64_mem_access_arbiter_pkg.sv
// snow64_mem_access_arbiter_pkg: shared widths, FSM/requester enums and the
// latched memory-command and per-cache result records.
package snow64_mem_access_arbiter_pkg;
   localparam int LINE_WIDTH = 256;
   localparam int ADDR_WIDTH = 64;
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
   typedef enum logic {REQ_ICACHE, REQ_DCACHE} requester_e;
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  we;
      logic [LINE_WIDTH-1:0] wdata;
   } mem_cmd_t;
   typedef struct packed {
      logic                  valid;
      logic [LINE_WIDTH-1:0] data;
   } port_out_t;
endpackage

// File: rtl/snow64_rr_picker_2.sv
// snow64_rr_picker_2: two-way round-robin pick; on a tie the side that did
// not win last time is chosen.
module snow64_rr_picker_2
   import snow64_mem_access_arbiter_pkg::*;
(
   input  logic       req_icache_i,
   input  logic       req_dcache_i,
   input  requester_e last_grant_i,
   output requester_e grant_o,
   output logic       any_grant_o
);
   assign any_grant_o = req_icache_i | req_dcache_i;
   assign grant_o = (req_icache_i & req_dcache_i)
                    ? ((last_grant_i == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE)
                    : (req_icache_i ? REQ_ICACHE : REQ_DCACHE);
endmodule

// File: rtl/snow64_mem_access_arbiter.sv
// snow64_mem_access_arbiter: shares one memory port between the icache and
// dcache, one transaction in flight, results returned as 1-cycle pulses.
module snow64_mem_access_arbiter
   import snow64_mem_access_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_icache_req,
   input  logic [ADDR_WIDTH-1:0] in_icache_addr,
   output logic                  out_icache_valid,
   output logic [LINE_WIDTH-1:0] out_icache_data,
   input  logic                  in_dcache_req,
   input  logic [ADDR_WIDTH-1:0] in_dcache_addr,
   input  logic                  in_dcache_we,
   input  logic [LINE_WIDTH-1:0] in_dcache_wdata,
   output logic                  out_dcache_valid,
   output logic [LINE_WIDTH-1:0] out_dcache_data,
   output logic                  out_mem_req,
   output logic [ADDR_WIDTH-1:0] out_mem_addr,
   output logic                  out_mem_we,
   output logic [LINE_WIDTH-1:0] out_mem_wdata,
   input  logic                  in_mem_valid,
   input  logic [LINE_WIDTH-1:0] in_mem_rdata
);
   state_e     state_q, state_d;
   requester_e last_q, last_d, owner_q, owner_d, pick;
   mem_cmd_t   cmd_q, cmd_d;
   port_out_t  ic_q, ic_d, dc_q, dc_d;
   logic       mem_req_q, mem_req_d, any;

   snow64_rr_picker_2 u_picker (
      .req_icache_i (in_icache_req),
      .req_dcache_i (in_dcache_req),
      .last_grant_i (last_q),
      .grant_o      (pick),
      .any_grant_o  (any)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      cmd_d     = cmd_q;
      mem_req_d = mem_req_q;
      ic_d      = '{valid: 1'b0, data: ic_q.data};
      dc_d      = '{valid: 1'b0, data: dc_q.data};
      unique case (state_q)
         ST_IDLE: if (any) begin
            state_d   = ST_BUSY;
            last_d    = pick;
            owner_d   = pick;
            mem_req_d = 1'b1;
            cmd_d     = (pick == REQ_ICACHE)
                        ? mem_cmd_t'{addr: in_icache_addr, we: 1'b0, wdata: '0}
                        : mem_cmd_t'{addr: in_dcache_addr, we: in_dcache_we, wdata: in_dcache_wdata};
         end
         ST_BUSY: if (in_mem_valid) begin
            state_d   = ST_DONE;
            mem_req_d = 1'b0;
            if (owner_q == REQ_ICACHE) ic_d = '{valid: 1'b1, data: in_mem_rdata};
            else dc_d = '{valid: 1'b1, data: cmd_q.we ? '0 : in_mem_rdata};
         end
         // Valid is visible this cycle; skipping arbitration lets the requester drop req.
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         last_q    <= REQ_DCACHE;
         owner_q   <= REQ_ICACHE;
         cmd_q     <= '0;
         mem_req_q <= 1'b0;
         ic_q      <= '0;
         dc_q      <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         cmd_q     <= cmd_d;
         mem_req_q <= mem_req_d;
         ic_q      <= ic_d;
         dc_q      <= dc_d;
      end
   end

   assign out_mem_req      = mem_req_q;
   assign out_mem_addr     = cmd_q.addr;
   assign out_mem_we       = cmd_q.we;
   assign out_mem_wdata    = cmd_q.wdata;
   assign out_icache_valid = ic_q.valid;
   assign out_icache_data  = ic_q.data;
   assign out_dcache_valid = dc_q.valid;
   assign out_dcache_data  = dc_q.data;
endmodule

// File: tb/tb_snow64_mem_access_arbiter.sv
// tb_snow64_mem_access_arbiter: table of single transactions plus hand-written
// arbitration, reset and stability sequences, checked through a scoreboard.
module tb_snow64_mem_access_arbiter;
   import snow64_mem_access_arbiter_pkg::*;

   logic                  clk = 1'b0, rst;
   logic                  in_icache_req, out_icache_valid, in_dcache_req, in_dcache_we;
   logic                  out_dcache_valid, out_mem_req, out_mem_we, in_mem_valid;
   logic [ADDR_WIDTH-1:0] in_icache_addr, in_dcache_addr, out_mem_addr;
   logic [LINE_WIDTH-1:0] out_icache_data, in_dcache_wdata, out_dcache_data;
   logic [LINE_WIDTH-1:0] out_mem_wdata, in_mem_rdata;

   snow64_mem_access_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .in_icache_req    (in_icache_req),
      .in_icache_addr   (in_icache_addr),
      .out_icache_valid (out_icache_valid),
      .out_icache_data  (out_icache_data),
      .in_dcache_req    (in_dcache_req),
      .in_dcache_addr   (in_dcache_addr),
      .in_dcache_we     (in_dcache_we),
      .in_dcache_wdata  (in_dcache_wdata),
      .out_dcache_valid (out_dcache_valid),
      .out_dcache_data  (out_dcache_data),
      .out_mem_req      (out_mem_req),
      .out_mem_addr     (out_mem_addr),
      .out_mem_we       (out_mem_we),
      .out_mem_wdata    (out_mem_wdata),
      .in_mem_valid     (in_mem_valid),
      .in_mem_rdata     (in_mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                    is_d;
      logic [ADDR_WIDTH-1:0] addr;
      logic                  we;
      logic [LINE_WIDTH-1:0] wdata;
      logic [LINE_WIDTH-1:0] rdata;
      int                    delay;
   } vec_t;

   vec_t                  sb[$];
   vec_t                  vecs[4];
   int                    checks = 0, errors = 0;
   logic [LINE_WIDTH-1:0] ic_m, dc_m;

   task automatic chk(input string name, input logic [LINE_WIDTH-1:0] act, input logic [LINE_WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      if (v.is_d) begin
         in_dcache_req   = 1'b1;
         in_dcache_addr  = v.addr;
         in_dcache_we    = v.we;
         in_dcache_wdata = v.wdata;
      end else begin
         in_icache_req  = 1'b1;
         in_icache_addr = v.addr;
      end
      sb.push_back(v);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_mem_req"}, out_mem_req, 0);
      chk({tag, "_valids"}, {out_icache_valid, out_dcache_valid}, 0);
   endtask

   task automatic wait_grant(output vec_t e, output int lat);
      if (sb.size() == 0) begin
         $display("FAIL scoreboard_empty got=0 want=1");
         errors++;
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $fatal(1);
      end
      e = sb.pop_front();
      lat = 0;
      while (!out_mem_req && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("grant_seen", out_mem_req, 1);
      chk("mem_addr", out_mem_addr, e.addr);
      chk("mem_we", out_mem_we, e.we);
      chk("mem_wdata", out_mem_wdata, e.is_d ? e.wdata : '0);
   endtask

   task automatic finish(input vec_t e, input bit drop, input bit extra);
      repeat (e.delay) @(negedge clk);
      chk("hold_req", out_mem_req, 1);
      chk("hold_addr", out_mem_addr, e.addr);
      chk("hold_we", out_mem_we, e.we);
      chk("busy_valids", {out_icache_valid, out_dcache_valid}, 0);
      in_mem_valid = 1'b1;
      in_mem_rdata = e.rdata;
      @(negedge clk);
      if (!extra) in_mem_valid = 1'b0;
      if (drop) begin
         in_icache_req = 1'b0;
         in_dcache_req = 1'b0;
      end
      if (e.is_d) dc_m = e.we ? '0 : e.rdata;
      else ic_m = e.rdata;
      chk("icache_valid", out_icache_valid, !e.is_d);
      chk("dcache_valid", out_dcache_valid, e.is_d);
      chk("icache_data", out_icache_data, ic_m);
      chk("dcache_data", out_dcache_data, dc_m);
      chk("req_drop", out_mem_req, 0);
      @(negedge clk);
      in_mem_valid = 1'b0;
      check_idle_outputs("after_done");
   endtask

   initial begin
      vec_t e;
      int   lat;
      rst = 1'b1;
      in_icache_req = 0; in_icache_addr = '0;
      in_dcache_req = 0; in_dcache_addr = '0; in_dcache_we = 0; in_dcache_wdata = '0;
      in_mem_valid = 0; in_mem_rdata = '0;
      ic_m = '0; dc_m = '0;
      vecs[0] = '{1'b0, 64'h1000, 1'b0, '0, {32{8'hAA}}, 3};
      vecs[1] = '{1'b1, 64'h2020, 1'b1, {32{8'h55}}, {32{8'h77}}, 1};
      vecs[2] = '{1'b1, 64'h3040, 1'b0, {32{8'hEE}}, {8{32'h1234_5678}}, 2};
      vecs[3] = '{1'b0, 64'hFFC0, 1'b0, '0, {4{64'hDEAD_BEEF_0BAD_F00D}}, 0};
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      chk("reset_addr", out_mem_addr, 0);
      chk("reset_we", out_mem_we, 0);
      chk("reset_wdata", out_mem_wdata, 0);
      chk("reset_idata", out_icache_data, 0);
      chk("reset_ddata", out_dcache_data, 0);
      rst = 1'b0;
      // Both requesting straight out of reset: icache first, then strict alternation.
      drive('{1'b0, 64'h5000, 1'b0, '0, {32{8'hA1}}, 1});
      drive('{1'b1, 64'h6000, 1'b0, {32{8'h99}}, {32{8'hD1}}, 2});
      sb.push_back('{1'b0, 64'h5000, 1'b0, '0, {32{8'hA2}}, 1});
      sb.push_back('{1'b1, 64'h6000, 1'b0, {32{8'h99}}, {32{8'hD2}}, 1});
      for (int k = 0; k < 4; k++) begin
         wait_grant(e, lat);
         chk("alt_latency", lat, 1);
         finish(e, k == 3, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         drive(vecs[i]);
         wait_grant(e, lat);
         chk("req_to_mem_latency", lat, 1);
         finish(e, 1'b1, 1'b0);
      end
      // Stray memory valid in IDLE, then one held through DONE.
      in_mem_valid = 1'b1;
      @(negedge clk);
      in_mem_valid = 1'b0;
      check_idle_outputs("idle_stray");
      @(negedge clk);
      check_idle_outputs("idle_stray2");
      drive('{1'b1, 64'h0A00, 1'b0, '0, {16{16'hC3C3}}, 1});
      wait_grant(e, lat);
      finish(e, 1'b1, 1'b1);
      @(negedge clk);
      check_idle_outputs("done_stray");
      // Requester inputs change while BUSY; latched command must hold.
      drive('{1'b1, 64'h3000, 1'b0, '0, {32{8'h3C}}, 2});
      wait_grant(e, lat);
      in_dcache_addr = 64'h4000;
      in_dcache_we = 1'b1;
      in_dcache_wdata = {32{8'hFF}};
      finish(e, 1'b1, 1'b0);
      // Reset while BUSY aborts; a late memory valid is ignored.
      drive('{1'b1, 64'h7000, 1'b1, {32{8'h11}}, {32{8'h22}}, 1});
      wait_grant(e, lat);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_dcache_req = 1'b0;
      ic_m = '0; dc_m = '0;
      check_idle_outputs("abort");
      chk("abort_addr", out_mem_addr, 0);
      chk("abort_we", out_mem_we, 0);
      chk("abort_wdata", out_mem_wdata, 0);
      chk("abort_idata", out_icache_data, 0);
      chk("abort_ddata", out_dcache_data, 0);
      in_mem_valid = 1'b1;
      in_mem_rdata = {32{8'h22}};
      @(negedge clk);
      in_mem_valid = 1'b0;
      check_idle_outputs("late_valid");
      @(negedge clk);
      check_idle_outputs("late_valid2");
      drive('{1'b0, 64'h8000, 1'b0, '0, {32{8'h81}}, 1});
      drive('{1'b1, 64'h9000, 1'b0, '0, {32{8'h91}}, 1});
      wait_grant(e, lat);
      chk("post_reset_tie_icache", e.is_d, 0);
      finish(e, 1'b0, 1'b0);
      wait_grant(e, lat);
      finish(e, 1'b1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
